score_text_renderer: RTL

Draws the "SCORE:dddd" overlay, 10 glyphs of 8x16 px each, at a fixed screen position. It is the reader side of the 256x8 glyph ROM. Each pixel it drives the ROM address from DrawX/DrawY and turns the returned row byte into a text_on pixel flag. Once per frame it converts the binary score to BCD with a sequential double-dabble engine, so the digits never change mid-frame.

---
 rtl/score_text_renderer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/score_text_renderer.sv
// "SCORE:dddd" text overlay: drives glyph ROM addresses from the beam position and
// registers the foreground flag; the score is converted to BCD once per frame.
module score_text_renderer #(
  parameter int X_POS         = 16,
  parameter int Y_POS         = 8,
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_start,
  input  logic [13:0] score,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [7:0]  font_addr,
  input  logic [7:0]  font_data,
  output logic        text_on,
  output logic        busy
);

  localparam logic [10:0] X_LO    = 11'(X_POS);
  localparam logic [10:0] X_HI    = 11'(X_POS + 80);
  localparam logic [10:0] Y_LO    = 11'(Y_POS);
  localparam logic [10:0] Y_HI    = 11'(Y_POS + 16);
  localparam logic [9:0]  X_OFF   = 10'(X_POS);
  localparam logic [9:0]  Y_OFF   = 10'(Y_POS);
  localparam logic [13:0] SAT_MAX = 14'd9999;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [13:0] shreg_q, shreg_d;
  logic [15:0] bcd_q, bcd_d, bcd_adj;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic        text_on_q, text_on_d;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values computed by the combinational processes.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      // NOTE: the displayed digits are ordinary flops, not a memory, so they are
      // reset along with the FSM; a reset mid-conversion shows 0000 immediately.
      state_q   <= IDLE;
      shreg_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
      text_on_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      text_on_q <= text_on_d;
    end
  end

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    digits_d = digits_q;
    bcd_adj  = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          shreg_d = (score > SAT_MAX) ? SAT_MAX : score;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_d, shreg_d} = {bcd_adj[14:0], shreg_q, 1'b0};
        cnt_d            = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = LOAD;
      end
      LOAD: begin
        digits_d = bcd_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // Pixel path: runs in every state against the currently displayed digits.
  logic [9:0] rel_x, rel_y;
  logic [3:0] slot, code, row;
  logic [2:0] col;
  logic       in_box, blank;
  logic [3:0] d3, d2, d1, d0;

  assign rel_x = DrawX - X_OFF;
  assign rel_y = DrawY - Y_OFF;
  assign slot  = rel_x[6:3];
  assign col   = rel_x[2:0];
  assign row   = rel_y[3:0];
  assign {d3, d2, d1, d0} = digits_q;

  assign in_box = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} < X_HI) &&
                  ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} < Y_HI);

  always_comb begin
    code  = 4'd0;
    blank = 1'b0;
    unique case (slot)
      4'd0:    code = 4'd11;
      4'd1:    code = 4'd12;
      4'd2:    code = 4'd13;
      4'd3:    code = 4'd14;
      4'd4:    code = 4'd15;
      4'd5:    code = 4'd10;
      4'd6: begin
        code  = d3;
        blank = BLANK_LEADING && (d3 == 4'd0);
      end
      4'd7: begin
        code  = d2;
        blank = BLANK_LEADING && (d3 == 4'd0) && (d2 == 4'd0);
      end
      4'd8: begin
        code  = d1;
        blank = BLANK_LEADING && (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0);
      end
      4'd9:    code = d0;
      default: code = 4'd0;
    endcase
  end

  assign font_addr = in_box ? {code, row} : 8'h00;
  // Bit 7 is the leftmost pixel, so column c selects bit 7-c, i.e. ~c.
  assign text_on_d = in_box & font_data[~col] & ~blank;
  assign text_on   = text_on_q;

endmodule
